// File: rtl/my_register_fifo_if.sv
// Handshake bundle for my_register_fifo: producer side (in/in_valid/in_ready),
// consumer side (out/out_valid/out_ready), flush and occupancy count.
interface my_register_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic                     flush;
    logic [WIDTH-1:0]         in;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         out;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, in, in_valid, out_ready,
        input  in_ready, out, out_valid, count
    );

    modport slave (
        input  flush, in, in_valid, out_ready,
        output in_ready, out, out_valid, count
    );
endinterface

// File: rtl/my_register_fifo.sv
// Small register-array FIFO with show-ahead output and independent valid/ready
// handshakes on the write and read sides.
module my_register_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    my_register_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] storage_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic             push_s;
    logic             pop_s;
    logic [CW-1:0]    count_nxt_s;

    // Handshake qualifiers use only the registered flags, so no input reaches an output.
    assign push_s = bus.in_valid & in_ready_r;
    assign pop_s  = out_valid_r & bus.out_ready;

    // Next occupancy: flush wins, otherwise push and pop cancel each other.
    always_comb begin
        count_nxt_s = count_r;
        if (bus.flush) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CW'(1);
                2'b01:   count_nxt_s = count_r - CW'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Storage, pointers, occupancy and the flow flags derived from the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                storage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            count_r     <= count_nxt_s;
            in_ready_r  <= (count_nxt_s != CW'(DEPTH));
            out_valid_r <= (count_nxt_s != {CW{1'b0}});
            // Flush rewinds the pointers but leaves the stored words in place.
            if (bus.flush) begin
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_s) begin
                    storage_r[wr_ptr_r] <= bus.in;
                    wr_ptr_r            <= wr_ptr_r + PW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = storage_r[rd_ptr_r];
    assign bus.count     = count_r;
endmodule

// File: tb/tb_my_register_fifo.sv
// Self-checking bench for my_register_fifo: directed boundary cases followed by
// random traffic, all checked against a queue-based reference model.
module tb_my_register_fifo;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic [WIDTH-1:0] model_q [$];

    my_register_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    my_register_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every visible output with what the queue model says.
    task automatic check_model(input string tag);
        check({tag, ".count"}, 32'(bus.count), 32'(model_q.size()));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(model_q.size() != 0));
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(model_q.size() != DEPTH));
        if (model_q.size() != 0) begin
            check({tag, ".out"}, 32'(bus.out), 32'(model_q[0]));
        end
    endtask

    // One clock of stimulus: drive, predict transfer from pre-edge state, update model, check.
    task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                        input logic fl, input string tag);
        logic do_push;
        logic do_pop;
        bus.in_valid  = iv;
        bus.in        = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        do_push = iv && (model_q.size() < DEPTH);
        do_pop  = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        check_model(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.in = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("rst.count", 32'(bus.count), 32'd0);
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out", 32'(bus.out), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-cycle with three words held
        for (int i = 0; i < 3; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0, "pre_rst");
        check("pre_rst.count3", 32'(bus.count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check("async_rst.count", 32'(bus.count), 32'd0);
        check("async_rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("async_rst.out", 32'(bus.out), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, extra push ignored, then drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b0, "fill");
        check("full.count", 32'(bus.count), 32'd4);
        check("full.in_ready", 32'(bus.in_ready), 32'd0);
        step(1'b1, 16'h0005, 1'b0, 1'b0, "push_when_full");
        check("full.ignored", 32'(bus.count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain.out", 32'(bus.out), 32'(i));
            step(1'b0, 16'h0000, 1'b1, 1'b0, "drain");
        end
        check("drained.out_valid", 32'(bus.out_valid), 32'd0);
        check("drained.count", 32'(bus.count), 32'd0);

        // Wrap-around with simultaneous push and pop at count 2
        step(1'b1, 16'hA000, 1'b0, 1'b0, "preload");
        step(1'b1, 16'hA001, 1'b0, 1'b0, "preload");
        for (int i = 0; i < 10; i++) begin
            check("wrap.out", 32'(bus.out), 32'(16'hA000 + 16'(i)));
            step(1'b1, 16'hA002 + 16'(i), 1'b1, 1'b0, "wrap");
            check("wrap.count", 32'(bus.count), 32'd2);
        end

        // Full boundary: pop only on the first edge, push accepted on the next
        step(1'b1, 16'hA00C, 1'b0, 1'b0, "refill");
        step(1'b1, 16'hA00D, 1'b0, 1'b0, "refill");
        w = bus.out;
        step(1'b1, 16'hDEAD, 1'b1, 1'b0, "full_bnd1");
        check("full_bnd1.count", 32'(bus.count), 32'd3);
        check("full_bnd1.head_moved", 32'(bus.out != w), 32'd1);
        step(1'b1, 16'hD00D, 1'b1, 1'b0, "full_bnd2");
        step(1'b1, 16'hD00E, 1'b0, 1'b0, "full_bnd3");
        check("full_bnd3.count", 32'(bus.count), 32'd4);

        // Empty boundary
        while (model_q.size() != 0) step(1'b0, 16'h0000, 1'b1, 1'b0, "empty_drain");
        step(1'b1, 16'hBEEF, 1'b1, 1'b0, "empty_bnd");
        check("empty_bnd.out", 32'(bus.out), 32'h0000BEEF);
        check("empty_bnd.count", 32'(bus.count), 32'd1);

        // Flush priority over push and pop
        step(1'b1, 16'h1111, 1'b0, 1'b0, "pre_flush");
        step(1'b1, 16'h2222, 1'b0, 1'b0, "pre_flush");
        check("pre_flush.count", 32'(bus.count), 32'd3);
        step(1'b1, 16'h1234, 1'b1, 1'b1, "flush");
        check("flush.count", 32'(bus.count), 32'd0);
        check("flush.out_valid", 32'(bus.out_valid), 32'd0);
        check("flush.in_ready", 32'(bus.in_ready), 32'd1);
        step(1'b1, 16'h5678, 1'b0, 1'b0, "post_flush");
        check("post_flush.out", 32'(bus.out), 32'h00005678);
        check("post_flush.count", 32'(bus.count), 32'd1);

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
